// File: rtl/mem_req_pkg.sv
// Shared types for the CPU-side memory request queue: the queued
// request record, the issue FSM states and the datapath widths.
package mem_req_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WDOG_W = 8;

  typedef struct packed {
    logic              store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order circular buffer of req_t entries.
// Ports: clk/rst (sync, active high), push/push_data, pop,
//        head (combinational from rd_ptr), full, empty, count.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  req_t        push_data,
  input  logic        pop,
  output req_t        head,
  output logic        full,
  output logic        empty,
  output logic [PW:0] count
);

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_request_queue.sv
// Load/store request queue between the CPU and the L1 data cache:
// buffers DEPTH requests, issues one at a time over VALID/READY with
// an ACK completion, and returns one response per request. A
// watchdog turns a lost ACK into an error response.
// Ports: CLK, RST (sync, active high);
//        REQ_*  CPU request side (valid/ready);
//        MEM_*  cache side (valid/ready address, ACK completion);
//        RSP_*  CPU response side (valid/ready).
// Optional: define MREQ_PERF_EN to add PERF_LOADS, PERF_STORES and
//        PERF_TIMEOUTS (16-bit saturating response counters).
module mem_request_queue
  import mem_req_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_STORE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              MEM_VALID,
  input  logic              MEM_READY,
  output logic              MEM_LOAD,
  output logic              MEM_STORE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_STORE,
  output logic              RSP_ERR,
  output logic [DATA_W-1:0] RSP_DATA
`ifdef MREQ_PERF_EN
  ,
  output logic [15:0]       PERF_LOADS,
  output logic [15:0]       PERF_STORES,
  output logic [15:0]       PERF_TIMEOUTS
`endif
);

  localparam int PW = $clog2(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_nxt;

  logic              push;
  logic              pop;
  logic              tmo;
  logic              issue;
  req_t              push_req;
  req_t              head;
  logic              full;
  logic              empty;
  logic [PW:0]       count;

  logic              rsp_store_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  assign push_req = '{
    store: REQ_STORE,
    addr:  REQ_ADDR,
    wdata: REQ_WDATA
  };

  // Ready comes from the registered count only: a pop in the
  // same cycle does not open a slot early.
  assign REQ_READY = ~full;
  assign push      = REQ_VALID & REQ_READY;

  mem_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // An ACK on the last watchdog cycle is checked first, so it wins
  // over the timeout.
  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    pop       = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        // A push this cycle lets the head issue next cycle.
        if (!empty || push) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (MEM_READY) begin
          if (MEM_ACK) begin
            pop       = 1'b1;
            state_nxt = RESP;
          end else begin
            wdog_nxt  = '0;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (MEM_ACK) begin
          pop       = 1'b1;
          state_nxt = RESP;
        end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
          pop       = 1'b1;
          tmo       = 1'b1;
          state_nxt = RESP;
        end else begin
          wdog_nxt  = wdog + 1'b1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_nxt = (count != '0) ? ISSUE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Response fields are latched with the pop and held through RESP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_store_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (pop) begin
      rsp_store_q <= head.store;
      rsp_err_q   <= tmo;
      rsp_data_q  <= (tmo || head.store) ? '0 : MEM_RDATA;
    end
  end

  // Address/data are gated so idle outputs stay zero.
  assign issue     = (state == ISSUE);
  assign MEM_VALID = issue;
  assign MEM_LOAD  = issue & ~head.store;
  assign MEM_STORE = issue & head.store;
  assign MEM_ADDR  = issue ? head.addr : '0;
  assign MEM_WDATA = issue ? head.wdata : '0;

  assign RSP_VALID = (state == RESP);
  assign RSP_STORE = rsp_store_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_DATA  = rsp_data_q;

`ifdef MREQ_PERF_EN
  logic rsp_acc;

  assign rsp_acc = RSP_VALID & RSP_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      PERF_LOADS    <= '0;
      PERF_STORES   <= '0;
      PERF_TIMEOUTS <= '0;
    end else if (rsp_acc) begin
      unique case (1'b1)
        rsp_err_q: begin
          if (PERF_TIMEOUTS != 16'hFFFF) begin
            PERF_TIMEOUTS <= PERF_TIMEOUTS + 1'b1;
          end
        end
        rsp_store_q: begin
          if (PERF_STORES != 16'hFFFF) begin
            PERF_STORES <= PERF_STORES + 1'b1;
          end
        end
        default: begin
          if (PERF_LOADS != 16'hFFFF) begin
            PERF_LOADS <= PERF_LOADS + 1'b1;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
// Self-checking bench for mem_request_queue: table-driven single
// requests plus fill/backpressure and mid-WAIT reset sequences.
module tb_mem_request_queue;

  localparam int TMO = 4;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_STORE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        MEM_VALID;
  logic        MEM_READY;
  logic        MEM_LOAD;
  logic        MEM_STORE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic        RSP_STORE;
  logic        RSP_ERR;
  logic [31:0] RSP_DATA;

  mem_request_queue #(
    .DEPTH   (4),
    .TIMEOUT (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_STORE (REQ_STORE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .MEM_VALID (MEM_VALID),
    .MEM_READY (MEM_READY),
    .MEM_LOAD  (MEM_LOAD),
    .MEM_STORE (MEM_STORE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_STORE (RSP_STORE),
    .RSP_ERR   (RSP_ERR),
    .RSP_DATA  (RSP_DATA)
  );

  typedef struct {
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy_dly;
    int          ack_dly;
    logic        tmo;
    int          rsp_dly;
  } vec_t;

  typedef struct {
    logic        store;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vt[8];
  int   checks;
  int   errors;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL global_timeout: sim still running, want done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, REQ_READY, 1);
    chk({tag, "_mem_valid"}, MEM_VALID, 0);
    chk({tag, "_mem_load"},  MEM_LOAD,  0);
    chk({tag, "_mem_store"}, MEM_STORE, 0);
    chk({tag, "_mem_addr"},  MEM_ADDR,  0);
    chk({tag, "_mem_wdata"}, MEM_WDATA, 0);
    chk({tag, "_rsp_valid"}, RSP_VALID, 0);
    chk({tag, "_rsp_store"}, RSP_STORE, 0);
    chk({tag, "_rsp_err"},   RSP_ERR,   0);
    chk({tag, "_rsp_data"},  RSP_DATA,  0);
  endtask

  task automatic chk_issue(input string tag, input vec_t v);
    chk({tag, "_valid"}, MEM_VALID, 1);
    chk({tag, "_addr"},  MEM_ADDR,  v.addr);
    chk({tag, "_wdata"}, MEM_WDATA, v.wdata);
    chk({tag, "_load"},  MEM_LOAD,  !v.store);
    chk({tag, "_store"}, MEM_STORE, v.store);
  endtask

  task automatic chk_rsp(input string tag, input exp_t e);
    chk({tag, "_valid"}, RSP_VALID, 1);
    chk({tag, "_store"}, RSP_STORE, e.store);
    chk({tag, "_err"},   RSP_ERR,   e.err);
    chk({tag, "_data"},  RSP_DATA,  e.data);
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got response, want none", tag);
    end else begin
      e = sb.pop_front();
      chk_rsp(tag, e);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   n;
    string tg;
    tg = $sformatf("v%0d", idx);
    REQ_VALID = 1'b1;
    REQ_STORE = v.store;
    REQ_ADDR  = v.addr;
    REQ_WDATA = v.wdata;
    chk({tg, "_req_ready"}, REQ_READY, 1);
    e.store = v.store;
    e.err   = v.tmo;
    e.data  = (v.tmo || v.store) ? 32'h0 : v.rdata;
    sb.push_back(e);
    tick();
    REQ_VALID = 1'b0;
    chk_issue({tg, "_issue"}, v);
    for (int k = 0; k < v.rdy_dly; k++) begin
      MEM_READY = 1'b0;
      MEM_ACK   = 1'b1;
      MEM_RDATA = 32'hBAD0_BAD0;
      tick();
      chk_issue({tg, "_hold"}, v);
    end
    MEM_READY = 1'b1;
    MEM_ACK   = (v.ack_dly == 0) && !v.tmo;
    MEM_RDATA = v.rdata;
    tick();
    MEM_READY = 1'b0;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    chk({tg, "_mem_valid_off"}, MEM_VALID, 0);
    if (!v.tmo && v.ack_dly > 0) begin
      for (int k = 1; k < v.ack_dly; k++) begin
        chk({tg, "_wait_rsp"}, RSP_VALID, 0);
        tick();
      end
      MEM_ACK   = 1'b1;
      MEM_RDATA = v.rdata;
      tick();
      MEM_ACK   = 1'b0;
      MEM_RDATA = 32'h0;
    end
    n = 0;
    while (!RSP_VALID && n < TMO + 8) begin
      tick();
      n++;
    end
    chk({tg, "_rsp_lat"}, n, v.tmo ? TMO : 0);
    for (int k = 0; k < v.rsp_dly; k++) begin
      RSP_READY = 1'b0;
      MEM_ACK   = 1'b1;
      MEM_RDATA = 32'h0BAD_0BAD;
      chk_rsp({tg, "_rsp_hold"}, e);
      tick();
    end
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    sb_pop({tg, "_rsp"});
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk({tg, "_rsp_done"}, RSP_VALID, 0);
  endtask

  task automatic fill_test();
    int   pi;
    int   got;
    int   cyc;
    logic acc;
    exp_t e;
    pi = 0;
    MEM_READY = 1'b0;
    REQ_VALID = 1'b1;
    REQ_STORE = 1'b0;
    for (int c = 0; c < 7; c++) begin
      REQ_ADDR  = 32'h1000 + 32'(pi) * 4;
      REQ_WDATA = 32'(pi);
      chk("fill_req_ready", REQ_READY, c < 4);
      acc = REQ_READY;
      if (acc) begin
        e.store = 1'b0;
        e.err   = 1'b0;
        e.data  = mem_fn(REQ_ADDR);
        sb.push_back(e);
      end
      tick();
      if (acc) pi++;
    end
    chk("fill_accepted", pi, 4);
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 80) begin
      MEM_READY = MEM_VALID;
      MEM_ACK   = MEM_VALID;
      MEM_RDATA = MEM_VALID ? mem_fn(MEM_ADDR) : 32'h0;
      RSP_READY = 1'b1;
      if (cyc == 0) chk("full_pop_ready", REQ_READY, 0);
      if (RSP_VALID) begin
        sb_pop($sformatf("fill_rsp%0d", got));
        got++;
      end
      acc = REQ_VALID && REQ_READY;
      if (acc) begin
        e.store = 1'b0;
        e.err   = 1'b0;
        e.data  = mem_fn(REQ_ADDR);
        sb.push_back(e);
      end
      tick();
      cyc++;
      if (acc) begin
        pi++;
        REQ_VALID = 1'b0;
      end
    end
    chk("fill_got", got, 5);
    chk("fill_pushed", pi, 5);
    MEM_READY = 1'b0;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    RSP_READY = 1'b0;
    REQ_VALID = 1'b0;
  endtask

  task automatic reset_test();
    int rsp_seen;
    int mem_seen;
    MEM_READY = 1'b0;
    REQ_VALID = 1'b1;
    REQ_STORE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      REQ_ADDR  = 32'h2000 + 32'(i) * 4;
      REQ_WDATA = 32'h0;
      tick();
    end
    REQ_VALID = 1'b0;
    chk("rst_pre_issue", MEM_VALID, 1);
    MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    tick();
    chk("rst_in_wait", MEM_VALID, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_idle("rst_mid");
    rsp_seen  = 0;
    mem_seen  = 0;
    RSP_READY = 1'b1;
    MEM_READY = 1'b1;
    MEM_ACK   = 1'b1;
    MEM_RDATA = 32'h1111_2222;
    for (int c = 0; c < 8; c++) begin
      if (RSP_VALID) rsp_seen++;
      if (MEM_VALID) mem_seen++;
      tick();
    end
    chk("rst_no_rsp", rsp_seen, 0);
    chk("rst_no_issue", mem_seen, 0);
    RSP_READY = 1'b0;
    MEM_READY = 1'b0;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
  endtask

  initial begin
    vec_t v;
    checks    = 0;
    errors    = 0;
    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_STORE = 1'b0;
    REQ_ADDR  = 32'h0;
    REQ_WDATA = 32'h0;
    MEM_READY = 1'b0;
    MEM_RDATA = 32'h0;
    MEM_ACK   = 1'b0;
    RSP_READY = 1'b0;

    vt[0] = '{1'b0, 32'h100, 32'h0,    32'hDEADBEEF, 0, 3, 1'b0, 0};
    vt[1] = '{1'b1, 32'h200, 32'h55,   32'h7777_7777, 0, 0, 1'b0, 1};
    vt[2] = '{1'b0, 32'h300, 32'h9,    32'h1234_5678, 6, 1, 1'b0, 0};
    vt[3] = '{1'b0, 32'h400, 32'h0,    32'hAAAA_AAAA, 0, 0, 1'b1, 2};
    vt[4] = '{1'b0, 32'h500, 32'h0,    32'hCAFE_F00D, 0, TMO, 1'b0, 0};
    vt[5] = '{1'b1, 32'h600, 32'h66,   32'h0,         2, 0, 1'b1, 0};
    vt[6] = '{1'b1, 32'h700, 32'hA5A5, 32'hFFFF_FFFF, 0, 2, 1'b0, 1};
    vt[7] = '{1'b0, 32'h800, 32'h0,    32'h0000_0001, 1, 0, 1'b0, 0};

    tick();
    tick();
    RST = 1'b0;
    chk_idle("reset");

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vt[i]);
    end

    fill_test();
    reset_test();

    v = '{1'b0, 32'h900, 32'h0, 32'h4242_4242, 0, 1, 1'b0, 0};
    run_vec(8, v);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
